// File: rtl/uart_rx_if.sv
// uart_rx_if: bundle of the serial line and the received-byte interface.
//   i_rxd       serial line into the receiver (idles high)
//   o_data      last correctly framed byte
//   o_valid     one-cycle strobe when o_data updates
//   o_frame_err one-cycle strobe when a stop bit is sampled low
//   o_busy      receiver is inside a frame (or waiting out a break)
// master: the receiver side; slave: the line driver / byte consumer side.
interface uart_rx_if;
  logic       i_rxd;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  modport master (
    input  i_rxd,
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_busy
  );

  modport slave (
    output i_rxd,
    input  o_data,
    input  o_valid,
    input  o_frame_err,
    input  o_busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with internal OVERSAMPLE-times oversampling.
// Ports:
//   i_clk    system clock, rising edge
//   i_reset  synchronous active-high reset
//   bus      uart_rx_if.master: i_rxd in; o_data, o_valid, o_frame_err,
//            o_busy out (all outputs registered)
// Start bit is confirmed at its middle, data and stop bits are sampled at
// their middles, LSB first. A low stop bit reports a frame error and the
// receiver then waits for the line to return high before re-arming.
module uart_rx #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16   // even, >= 4
) (
  input  logic     i_clk,
  input  logic     i_reset,
  uart_rx_if.master bus
);

  localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TC_W    = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TC_W-1:0]  MID_START = TC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TC_W-1:0]  FULL_BIT  = TC_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  // Two-flop synchroniser; idle-high reset value avoids a false start.
  logic rxd_meta_q, rxd_s_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= bus.i_rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  state_e           state_q;
  logic [TC_W-1:0]  tcnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             ferr_q;
  logic             busy_q;

  // Oversampling divider. Cleared on the detected start edge so that the
  // tick phase, and hence every mid-bit sample, is aligned to that edge.
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic             start_det;

  assign start_det = (state_q == S_IDLE) && !rxd_s_q;
  assign tick      = (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q + 1'b1;
    if (start_det || tick) begin
      div_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // Receive FSM; outputs are registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      tcnt_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rxd_s_q) begin
            state_q <= S_START;
            tcnt_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (tick) begin
            if (tcnt_q == MID_START) begin
              tcnt_q <= '0;
              if (rxd_s_q) begin
                // Line already back high at mid-start: treat as a glitch.
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q   <= S_DATA;
                bit_idx_q <= '0;
              end
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (tcnt_q == FULL_BIT) begin
              tcnt_q  <= '0;
              shift_q <= {rxd_s_q, shift_q[7:1]};
              if (bit_idx_q == 3'd7) begin
                state_q <= S_STOP;
              end else begin
                bit_idx_q <= bit_idx_q + 1'b1;
              end
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            if (tcnt_q == FULL_BIT) begin
              tcnt_q <= '0;
              if (rxd_s_q) begin
                // Re-arm at mid-stop so a back-to-back start edge is caught.
                data_q  <= shift_q;
                valid_q <= 1'b1;
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                ferr_q  <= 1'b1;
                state_q <= S_BREAK;
              end
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
        end
        S_BREAK: begin
          // A held-low line must not be mistaken for a new start bit.
          if (rxd_s_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_frame_err = ferr_q;
  assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed plus randomized bench for uart_rx at
// CLK_FREQ=1.6 MHz, 10 kbaud, 16x oversampling (160 clocks per bit).
// Expected bytes and pulse times come from a frame-level model: a good frame
// yields its byte once, LAT clocks after the start edge is driven.
module tb_uart_rx;

  localparam int unsigned BIT = 160;
  // 2 synchroniser clocks + 10*(8 + 9*16) divider clocks + 1 output register.
  localparam int unsigned LAT = 2 + 10 * (8 + 9 * 16) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ  (1_600_000),
    .BAUD_RATE (10_000),
    .OVERSAMPLE(16)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder: every o_valid / o_frame_err cycle with its timestamp.
  logic [7:0]  vq_d[$];
  int unsigned vq_t[$];
  int unsigned fq_t[$];
  int unsigned viol = 0;
  logic        prev_v = 1'b0;
  logic        prev_f = 1'b0;

  always @(negedge clk) begin
    if (bus.o_valid) begin
      vq_d.push_back(bus.o_data);
      vq_t.push_back(cyc);
    end
    if (bus.o_frame_err) fq_t.push_back(cyc);
    if (bus.o_valid && bus.o_frame_err) viol++;
    if (bus.o_valid && prev_v) viol++;
    if (bus.o_frame_err && prev_f) viol++;
    prev_v = bus.o_valid;
    prev_f = bus.o_frame_err;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int unsigned obs,
                         input int unsigned lo, input int unsigned hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_clks(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  d;
    int unsigned t0;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned v_rd = 0;
  int unsigned f_rd = 0;
  logic [7:0]  last_good = 8'h00;

  // Drives one 10-bit frame. With rst_at != 0, i_reset is pulsed for one
  // clock at that offset and the reset-state outputs are checked next cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int unsigned rst_at, output int unsigned t0);
    logic [9:0]  fr;
    int unsigned k;
    fr = {stop, d, 1'b0};
    t0 = cyc;
    for (int unsigned b = 0; b < 10; b++) begin
      for (int unsigned c = 0; c < BIT; c++) begin
        k = b * BIT + c;
        if (rst_at != 0 && k == rst_at + 1) begin
          chk("rst_mid_data", {24'h0, bus.o_data}, 32'h00);
          chk("rst_mid_valid", {31'h0, bus.o_valid}, 32'h0);
          chk("rst_mid_ferr", {31'h0, bus.o_frame_err}, 32'h0);
          chk("rst_mid_busy", {31'h0, bus.o_busy}, 32'h0);
        end
        bus.i_rxd = fr[b];
        rst = (rst_at != 0 && k == rst_at);
        @(negedge clk);
      end
    end
  endtask

  task automatic expect_good(input logic [7:0] d, input int unsigned t0);
    exp_t e;
    e.d  = d;
    e.t0 = t0;
    exp_q.push_back(e);
    last_good = d;
  endtask

  // Compare all pulses recorded since the last call against the model.
  task automatic compare_model(input string tag);
    int unsigned n;
    n = vq_d.size() - v_rd;
    chk({tag, "_nvalid"}, n, exp_q.size());
    chk({tag, "_nferr"}, fq_t.size() - f_rd, 0);
    foreach (exp_q[i]) begin
      if (v_rd + i < vq_d.size()) begin
        chk($sformatf("%s_data%0d", tag, i), {24'h0, vq_d[v_rd+i]}, {24'h0, exp_q[i].d});
        chk_rng($sformatf("%s_lat%0d", tag, i), vq_t[v_rd+i] - exp_q[i].t0, LAT - 1, LAT + 1);
      end
    end
    v_rd = vq_d.size();
    f_rd = fq_t.size();
    exp_q.delete();
  endtask

  int unsigned t0;
  int unsigned tf;
  logic [7:0]  rd;

  initial begin
    bus.i_rxd = 1'b1;
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    chk("reset_data", {24'h0, bus.o_data}, 32'h00);
    chk("reset_valid", {31'h0, bus.o_valid}, 32'h0);
    chk("reset_ferr", {31'h0, bus.o_frame_err}, 32'h0);
    chk("reset_busy", {31'h0, bus.o_busy}, 32'h0);

    // Idle line.
    wait_clks(2000);
    chk("idle_data", {24'h0, bus.o_data}, 32'h00);
    chk("idle_busy", {31'h0, bus.o_busy}, 32'h0);
    compare_model("idle");

    // Single good frame.
    send_frame(8'hA5, 1'b1, 0, t0);
    expect_good(8'hA5, t0);
    wait_clks(20);
    compare_model("a5");

    // Glitch shorter than half a bit.
    bus.i_rxd = 1'b0;
    wait_clks(50);
    chk("glitch_busy_hi", {31'h0, bus.o_busy}, 32'h1);
    bus.i_rxd = 1'b1;
    wait_clks(40);
    chk("glitch_busy_lo", {31'h0, bus.o_busy}, 32'h0);
    wait_clks(200);
    compare_model("glitch");

    // Low stop bit followed by a held-low line.
    send_frame(8'h3C, 1'b0, 0, t0);
    wait_clks(500);
    chk("ferr_busy_held", {31'h0, bus.o_busy}, 32'h1);
    chk("ferr_count", fq_t.size() - f_rd, 1);
    chk("ferr_nvalid", vq_d.size() - v_rd, 0);
    chk("ferr_data_kept", {24'h0, bus.o_data}, {24'h0, last_good});
    if (fq_t.size() > f_rd) begin
      tf = fq_t[f_rd];
      chk_rng("ferr_lat", tf - t0, LAT - 1, LAT + 1);
    end
    f_rd = fq_t.size();
    bus.i_rxd = 1'b1;
    wait_clks(10);
    chk("ferr_busy_release", {31'h0, bus.o_busy}, 32'h0);
    wait_clks(200);
    compare_model("ferr_after");

    // Back-to-back frames, one stop bit each.
    send_frame(8'h00, 1'b1, 0, t0);
    expect_good(8'h00, t0);
    send_frame(8'hFF, 1'b1, 0, t0);
    expect_good(8'hFF, t0);
    send_frame(8'h55, 1'b1, 0, t0);
    expect_good(8'h55, t0);
    wait_clks(20);
    compare_model("b2b");

    // Random bytes with random idle gaps (zero gap = back-to-back).
    for (int i = 0; i < 8; i++) begin
      wait_clks($urandom_range(0, 200));
      rd = 8'($urandom);
      send_frame(rd, 1'b1, 0, t0);
      expect_good(rd, t0);
    end
    wait_clks(20);
    compare_model("rand");

    // Reset during bit 4 of 8'h81 (bit 4 spans clocks 800..959 of the frame).
    send_frame(8'h81, 1'b1, 880, t0);
    chk("rst_frame_nvalid", vq_d.size() - v_rd, 0);
    chk("rst_frame_nferr", fq_t.size() - f_rd, 0);
    // The line is still low after the reset, so the receiver re-syncs on the
    // remainder of the frame and may report that fragment; let it drain.
    wait_clks(2500);
    v_rd = vq_d.size();
    f_rd = fq_t.size();
    chk("rst_drain_busy", {31'h0, bus.o_busy}, 32'h0);
    send_frame(8'h81, 1'b1, 0, t0);
    expect_good(8'h81, t0);
    wait_clks(20);
    compare_model("after_rst");

    chk("pulse_rules", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: the receive-side counterpart of the board's switch-driven transmitter.
- Samples the serial line with a 16x oversampling tick generated internally from i_clk.
- Validates the start and stop bits and presents each received byte on a parallel bus with a one-cycle valid strobe.
- Intended for loop-back with the transmitter (o_txd -> i_rxd) and for driving LEDs or a display on the same board.

Parameters:
- CLK_FREQ, 100_000_000, i_clk frequency in Hz.
- BAUD_RATE, 9600, line bit rate in bit/s.
- OVERSAMPLE, 16, ticks per bit period; must be even and >= 4.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_rxd  input  1  asynchronous serial line; idles high.
- o_data  output  8  last correctly framed byte; holds until the next good frame.
- o_valid  output  1  one-cycle pulse when o_data is updated.
- o_frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- o_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (i_reset=1 at a clock edge):
  - o_data=8'h00, o_valid=0, o_frame_err=0, o_busy=0.
  - FSM=IDLE; all counters=0; synchroniser flops=1.
  - Reset mid-frame abandons the frame with no pulses.
- Synchroniser: i_rxd passes through 2 flops (reset value 1). All decisions use the second flop, rxd_s.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer-truncated.
  - Counter runs 0..DIV-1 and emits a one-cycle tick at DIV-1.
  - Cleared to 0 on entry to START, so sampling aligns to the detected edge.
- Tick counter tcnt counts ticks within the current bit.
- FSM states and transitions:
  - IDLE: when rxd_s==0, go to START; clear the divider and tcnt.
  - START: on tick OVERSAMPLE/2 (mid-start-bit):
    - rxd_s==1: false start (glitch); return to IDLE, no pulses.
    - rxd_s==0: go to DATA; bit index=0; tcnt=0.
  - DATA: on each tick OVERSAMPLE (mid-bit):
    - Shift rxd_s into a shift register, LSB first.
    - After the 8th bit (index 7), go to STOP.
  - STOP: on tick OVERSAMPLE (mid-stop-bit):
    - rxd_s==1: o_data <= shift register; o_valid=1 next cycle; go to IDLE.
    - rxd_s==0: o_frame_err=1 next cycle; o_data unchanged; go to BREAK.
  - BREAK: stay until rxd_s==1, then go to IDLE. This prevents a held-low line (break) from re-triggering as a start bit.
- Latency: o_valid rises exactly 1 clock after the mid-stop sample edge. From the i_rxd falling edge this is 2 + DIV*(OVERSAMPLE/2 + 9*OVERSAMPLE) + 1 clocks, +/-1 clock of synchroniser phase.
- Back-to-back frames: returning to IDLE at mid-stop lets the next start edge be caught with no idle gap beyond the remaining half stop bit.
- Pulse exclusivity: o_valid and o_frame_err are never high together. Neither is ever high for more than 1 cycle.
- o_busy equals (state != IDLE) and is registered with the state.

Test Plan (CLK_FREQ=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16 -> DIV=10, bit=160 clocks):
- Reset then idle line high for 2000 clocks -> o_data=8'h00, o_valid never asserted, o_busy=0.
- Send 8'hA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> exactly one o_valid pulse; o_data=8'hA5; o_frame_err=0; o_valid timing per the latency formula.
- i_rxd low for 50 clocks then high -> false start: o_busy high then back to 0 by about 82 clocks; no o_valid, no o_frame_err.
- Send 8'h3C with stop bit forced 0, hold line low 500 clocks, then high -> one o_frame_err pulse; o_data keeps its prior value; o_busy stays 1 until the line returns high.
- Back-to-back 8'h00, 8'hFF, 8'h55 with 1 stop bit each -> three o_valid pulses with o_data 8'h00, 8'hFF, 8'h55 in order.
- Assert i_reset for 1 cycle during bit 4 of 8'h81 -> no pulses; outputs at reset values; the next clean frame 8'h81 is received correctly.
